// File: rtl/mem_access.sv
// Memory stage: turns the ALU result into a RV32I load/store over a
// valid/ready request channel and a valid-only response channel. Handles
// lane steering, byte strobes, load extension and misalignment traps.
module mem_access #(
    parameter int unsigned DWIDTH = 32,
    parameter int unsigned AWIDTH = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_i,
    input  logic [AWIDTH-1:0] addr_i,
    input  logic [DWIDTH-1:0] wdata_i,
    input  logic [2:0]        funct3_i,
    input  logic              memren_i,
    input  logic              memwen_i,
    output logic              req_valid_o,
    input  logic              req_ready_i,
    output logic              req_we_o,
    output logic [AWIDTH-1:0] req_addr_o,
    output logic [DWIDTH-1:0] req_wdata_o,
    output logic [3:0]        req_strb_o,
    input  logic              rsp_valid_i,
    input  logic [DWIDTH-1:0] rsp_data_i,
    output logic [DWIDTH-1:0] rdata_o,
    output logic              done_o,
    output logic              stall_o,
    output logic              err_o
);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

    state_e            state_q, state_d;
    logic [AWIDTH-1:0] addr_q, addr_d;
    logic [DWIDTH-1:0] wdata_q, wdata_d;
    logic [2:0]        funct3_q, funct3_d;
    logic              we_q, we_d;
    logic              err_q, err_d;
    logic [DWIDTH-1:0] rdata_q, rdata_d;

    logic              is_mem;
    logic              acc_err;
    logic [DWIDTH-1:0] lane;
    logic [DWIDTH-1:0] load_fmt;
    logic [DWIDTH-1:0] store_data;
    logic [3:0]        store_strb;

    // Classify the instruction presented in IDLE and flag illegal/misaligned accesses.
    always_comb begin
        is_mem  = memren_i | memwen_i;
        acc_err = 1'b0;
        if (memren_i && memwen_i) begin
            acc_err = 1'b1;
        end else if (memren_i && (funct3_i == 3'd3 || funct3_i == 3'd6 || funct3_i == 3'd7)) begin
            acc_err = 1'b1;
        end else if (memwen_i && funct3_i > 3'd2) begin
            acc_err = 1'b1;
        end else if (funct3_i[1:0] == 2'b01 && addr_i[0]) begin
            acc_err = 1'b1;
        end else if (funct3_i[1:0] == 2'b10 && addr_i[1:0] != 2'b00) begin
            acc_err = 1'b1;
        end
    end

    // Shift the addressed byte/halfword down to bit 0 and extend per funct3.
    always_comb begin
        lane = rsp_data_i >> {addr_q[1:0], 3'b000};
        case (funct3_q)
            3'b000:  load_fmt = {{24{lane[7]}}, lane[7:0]};
            3'b001:  load_fmt = {{16{lane[15]}}, lane[15:0]};
            3'b100:  load_fmt = {24'd0, lane[7:0]};
            3'b101:  load_fmt = {16'd0, lane[15:0]};
            default: load_fmt = lane;
        endcase
    end

    // Replicate store data across lanes so the strobes alone select the bytes.
    always_comb begin
        case (funct3_q[1:0])
            2'b00: begin
                store_data = {4{wdata_q[7:0]}};
                store_strb = 4'b0001 << addr_q[1:0];
            end
            2'b01: begin
                store_data = {2{wdata_q[15:0]}};
                store_strb = 4'b0011 << addr_q[1:0];
            end
            default: begin
                store_data = wdata_q;
                store_strb = 4'b1111;
            end
        endcase
    end

    // Next-state and capture logic.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        funct3_d = funct3_q;
        we_d     = we_q;
        err_d    = err_q;
        rdata_d  = rdata_q;
        case (state_q)
            StIdle: begin
                if (valid_i && is_mem) begin
                    addr_d   = addr_i;
                    wdata_d  = wdata_i;
                    funct3_d = funct3_i;
                    we_d     = memwen_i;
                    err_d    = acc_err;
                    state_d  = acc_err ? StDone : StReq;
                end
            end
            StReq: begin
                if (req_ready_i) begin
                    state_d = we_q ? StDone : StWait;
                end
            end
            StWait: begin
                if (rsp_valid_i) begin
                    rdata_d = load_fmt;
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and captured-operand registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            wdata_q  <= '0;
            funct3_q <= '0;
            we_q     <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            funct3_q <= funct3_d;
            we_q     <= we_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
        end
    end

    // Outputs; reset gating keeps the combinational IDLE paths quiet during reset.
    always_comb begin
        req_valid_o = 1'b0;
        req_we_o    = 1'b0;
        req_addr_o  = '0;
        req_wdata_o = '0;
        req_strb_o  = 4'b0000;
        done_o      = 1'b0;
        stall_o     = 1'b0;
        err_o       = 1'b0;
        if (!reset) begin
            case (state_q)
                StIdle: begin
                    if (valid_i) begin
                        done_o  = ~is_mem;
                        stall_o = is_mem;
                    end
                end
                StReq: begin
                    req_valid_o = 1'b1;
                    req_we_o    = we_q;
                    req_addr_o  = {addr_q[AWIDTH-1:2], 2'b00};
                    req_wdata_o = we_q ? store_data : '0;
                    req_strb_o  = we_q ? store_strb : 4'b0000;
                    stall_o     = 1'b1;
                end
                StWait: stall_o = 1'b1;
                default: begin
                    done_o = 1'b1;
                    err_o  = err_q;
                end
            endcase
        end
    end

    assign rdata_o = rdata_q;

endmodule
